// File: rtl/loop_fb_pkg.sv
// loop_fb_pkg: shared state/result types and constants for the loop feedback scheduler
package loop_fb_pkg;
  typedef enum logic [2:0] {IDLE, ARB, EN, COOL, RPT} state_e;
  typedef enum logic [1:0] {PASS, RETRY, FAIL} result_e;
  localparam int SYNC_STAGES = 2;
endpackage

// File: rtl/loop_fb_rr_arb.sv
// loop_fb_rr_arb: combinational round-robin pick of the first set req at or after ptr
module loop_fb_rr_arb #(
  parameter int NUM_CH = 4,
  localparam int IW = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IW-1:0]     ptr,
  output logic [NUM_CH-1:0] onehot,
  output logic [IW-1:0]     idx
);
  int j;
  always_comb begin
    onehot = '0;
    idx = '0;
    j = 0;
    // scan farthest-first so the nearest set request is the last one written
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % NUM_CH;
      if (req[j]) begin
        onehot = NUM_CH'(1) << j;
        idx = IW'(j);
      end
    end
  end
endmodule

// File: rtl/loop_feedback_sched.sv
// loop_feedback_sched: round-robin scheduler for the shared loop feedback path with
// latency timing, timeout retries and a pass/fail report per session
module loop_feedback_sched
  import loop_fb_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CNT_W     = 12,
  parameter int TIMEOUT   = 2000,
  parameter int MAX_RETRY = 2,
  parameter int GAP       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_CH-1:0]         req,
  input  logic                      abort,
  input  logic                      ok_feedback,
  output logic [NUM_CH-1:0]         grant,
  output logic                      enable_feedback,
  output logic                      busy,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout_err,
  output logic [CNT_W-1:0]          latency,
  output logic [$clog2(NUM_CH)-1:0] ch_id,
  output logic [2:0]                retries
);
  localparam int IW = $clog2(NUM_CH);
  localparam int GW = $clog2(GAP + 1);
  if (TIMEOUT < 1 || TIMEOUT >= 2 ** CNT_W) begin : g_chk
    $error("TIMEOUT must fit in CNT_W bits");
  end
  state_e                   state;
  result_e                  res;
  logic [IW-1:0]            ptr, pick_idx;
  logic [NUM_CH-1:0]        pick;
  logic [CNT_W-1:0]         cnt, lat_q;
  logic [GW-1:0]            gcnt;
  logic [2:0]               att;
  logic [SYNC_STAGES-1:0]   sync;
  logic                     ok_s, to_hit, more;
  loop_fb_rr_arb #(.NUM_CH(NUM_CH)) u_arb (.req(req), .ptr(ptr), .onehot(pick), .idx(pick_idx));
  assign ok_s = sync[SYNC_STAGES-1];
  assign to_hit = cnt == CNT_W'(TIMEOUT - 1);
  assign more = att < 3'(MAX_RETRY);
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      res <= FAIL;
      ptr <= '0;
      grant <= '0;
      ch_id <= '0;
      enable_feedback <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout_err <= 1'b0;
      latency <= '0;
      retries <= '0;
      cnt <= '0;
      lat_q <= '0;
      gcnt <= '0;
      att <= '0;
      sync <= '0;
    end else begin
      // synchronizer restarts each attempt so a level already high still shows the sync delay
      sync <= (state == EN) ? {sync[SYNC_STAGES-2:0], ok_feedback} : '0;
      done <= 1'b0;
      case (state)
        IDLE: if (|req) state <= ARB;
        ARB: begin
          if (!(|req)) state <= IDLE;
          else begin
            grant <= pick;
            ch_id <= pick_idx;
            ptr <= (pick_idx == IW'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            att <= '0;
            cnt <= '0;
            gcnt <= '0;
            res <= FAIL;
            enable_feedback <= !abort;
            state <= abort ? COOL : EN;
          end
        end
        EN: begin
          cnt <= (&cnt) ? cnt : cnt + 1'b1;
          gcnt <= '0;
          if (abort || ok_s || to_hit) begin
            state <= COOL;
            enable_feedback <= 1'b0;
            res <= abort ? FAIL : ok_s ? PASS : more ? RETRY : FAIL;
          end
          if (!abort && ok_s) lat_q <= cnt;
          if (!abort && !ok_s && to_hit && more) att <= att + 1'b1;
        end
        COOL: begin
          if (gcnt == GW'(GAP - 1)) begin
            if (res == RETRY) begin
              state <= EN;
              enable_feedback <= 1'b1;
              cnt <= '0;
            end else begin
              state <= RPT;
              done <= 1'b1;
              pass <= res == PASS;
              timeout_err <= res != PASS;
              latency <= (res == PASS) ? lat_q : '1;
              retries <= att;
            end
          end else gcnt <= gcnt + 1'b1;
        end
        RPT: begin
          grant <= '0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_loop_feedback_sched.sv
// tb_loop_feedback_sched: table-driven and randomized sessions checked against a session-level model
module tb_loop_feedback_sched;
  localparam int TIMEOUT = 2000;
  localparam int MAX_RETRY = 2;
  localparam int GAP = 16;
  typedef struct {
    logic [3:0]  req;
    int          d0, d1, d2;
    int          ab;
    logic        exp_pass;
    logic [11:0] exp_lat;
    logic [1:0]  exp_ch;
    logic [2:0]  exp_ret;
  } vec_t;
  logic clk, rst, abort, ok_feedback;
  logic [3:0] req, grant;
  logic enable_feedback, busy, done, pass, timeout_err;
  logic [11:0] latency;
  logic [1:0] ch_id;
  logic [2:0] retries;
  int nvec = 0, nbad = 0, mptr = 0;
  vec_t tbl[11];
  vec_t tv;
  loop_feedback_sched #(.NUM_CH(4), .CNT_W(12), .TIMEOUT(TIMEOUT), .MAX_RETRY(MAX_RETRY), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .req(req), .abort(abort), .ok_feedback(ok_feedback), .grant(grant),
    .enable_feedback(enable_feedback), .busy(busy), .done(done), .pass(pass),
    .timeout_err(timeout_err), .latency(latency), .ch_id(ch_id), .retries(retries));
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nbad++;
      $display("FAIL %s: got %0d, expected %0d", n, act, exp);
    end
  endtask
  // ok driven in the cycle where the attempt's cycle count is d becomes visible d+2 cycles in
  function automatic vec_t model(input logic [3:0] r, input int d0, input int d1, input int d2);
    vec_t v;
    int d[3];
    d[0] = d0; d[1] = d1; d[2] = d2;
    v.req = r; v.d0 = d0; v.d1 = d1; v.d2 = d2; v.ab = -1;
    v.exp_pass = 0; v.exp_lat = 12'hFFF; v.exp_ret = 3'(MAX_RETRY); v.exp_ch = 0;
    for (int a = MAX_RETRY; a >= 0; a--)
      if (d[a] >= 0 && d[a] + 2 <= TIMEOUT - 1) begin
        v.exp_pass = 1; v.exp_lat = 12'(d[a] + 2); v.exp_ret = 3'(a);
      end
    for (int i = 0; i < 4; i++)
      if (r[(mptr + i) % 4]) begin
        v.exp_ch = 2'((mptr + i) % 4);
        break;
      end
    return v;
  endfunction
  task automatic run(input vec_t v);
    int d[3];
    int att, k, low, gbad, nat, expl;
    int pl[$];
    logic prev, multi, got;
    d[0] = v.d0; d[1] = v.d1; d[2] = v.d2;
    att = -1; k = 0; low = 0; gbad = 0; prev = 0; multi = 0; got = 0;
    req = v.req;
    for (int c = 0; c < 10000 && !got; c++) begin
      @(posedge clk); #1;
      if ($countones(grant) > 1) multi = 1;
      if (done) begin
        got = 1;
        if (low != GAP) gbad++;
      end else if (enable_feedback && !prev) begin
        if (att >= 0 && low != GAP) gbad++;
        att++; k = 0;
      end else if (enable_feedback) k++;
      else if (prev) begin
        pl.push_back(k + 1); low = 1;
      end else if (att >= 0) low++;
      prev = enable_feedback;
      ok_feedback = enable_feedback && att >= 0 && att < 3 && d[att] >= 0 && k >= d[att];
      abort = enable_feedback && att == 0 && k == v.ab;
    end
    ok_feedback = 0; abort = 0;
    if (!got) chk("session_done", 0, 1);
    else begin
      chk("pass", pass, v.exp_pass);
      chk("timeout_err", timeout_err, !v.exp_pass);
      chk("latency", latency, v.exp_lat);
      chk("ch_id", ch_id, v.exp_ch);
      chk("retries", retries, v.exp_ret);
      chk("grant", grant, 1 << v.exp_ch);
      chk("multi_grant", multi, 0);
      nat = v.exp_ret + 1;
      chk("pulses", pl.size(), nat);
      for (int i = 0; i < pl.size() && i < nat; i++) begin
        expl = (i < nat - 1) ? TIMEOUT : v.exp_pass ? d[i] + 3 : v.ab >= 0 ? v.ab + 1 : TIMEOUT;
        chk("pulse_len", pl[i], expl);
      end
      chk("gap_bad", gbad, 0);
    end
    mptr = (v.exp_ch + 1) % 4;
  endtask
  initial begin
    rst = 1; req = 0; abort = 0; ok_feedback = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0); chk("rst_en", enable_feedback, 0); chk("rst_busy", busy, 0);
    chk("rst_done", done, 0); chk("rst_pass", pass, 0); chk("rst_terr", timeout_err, 0);
    chk("rst_lat", latency, 0); chk("rst_ch", ch_id, 0); chk("rst_ret", retries, 0);
    rst = 0;
    tbl[0]  = '{4'b1111, 0, -1, -1, -1, 1'b1, 12'd2, 2'd0, 3'd0};
    tbl[1]  = '{4'b1111, 7, -1, -1, -1, 1'b1, 12'd9, 2'd1, 3'd0};
    tbl[2]  = '{4'b1111, 30, -1, -1, -1, 1'b1, 12'd32, 2'd2, 3'd0};
    tbl[3]  = '{4'b1111, 1, -1, -1, -1, 1'b1, 12'd3, 2'd3, 3'd0};
    tbl[4]  = '{4'b1111, 200, -1, -1, -1, 1'b1, 12'd202, 2'd0, 3'd0};
    tbl[5]  = '{4'b0001, 100, -1, -1, -1, 1'b1, 12'd102, 2'd0, 3'd0};
    tbl[6]  = '{4'b0010, -1, 50, -1, -1, 1'b1, 12'd52, 2'd1, 3'd1};
    tbl[7]  = '{4'b1000, -1, -1, -1, -1, 1'b0, 12'hFFF, 2'd3, 3'd2};
    tbl[8]  = '{4'b0100, -1, -1, -1, 40, 1'b0, 12'hFFF, 2'd2, 3'd0};
    tbl[9]  = '{4'b0011, 1997, -1, -1, -1, 1'b1, 12'd1999, 2'd0, 3'd0};
    tbl[10] = '{4'b0011, 1998, 3, -1, -1, 1'b1, 12'd5, 2'd1, 3'd1};
    for (int i = 0; i < 11; i++) run(tbl[i]);
    for (int i = 0; i < 6; i++) begin
      int dd[3];
      for (int a = 0; a < 3; a++)
        case ($urandom_range(0, 5))
          0: dd[a] = -1;
          1: dd[a] = TIMEOUT - 3;
          2: dd[a] = TIMEOUT - 2;
          default: dd[a] = int'($urandom_range(0, 300));
        endcase
      tv = model(4'($urandom_range(1, 15)), dd[0], dd[1], dd[2]);
      run(tv);
    end
    req = 4'b0100;
    begin
      int c = 0;
      while (!enable_feedback && c < 200) begin
        @(posedge clk); #1;
        c++;
      end
    end
    chk("rst_seq_en_rise", enable_feedback, 1);
    repeat (10) @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    chk("midrst_en", enable_feedback, 0); chk("midrst_grant", grant, 0);
    chk("midrst_busy", busy, 0); chk("midrst_done", done, 0);
    mptr = 0;
    tv = '{4'b1010, 10, -1, -1, -1, 1'b1, 12'd12, 2'd1, 3'd0};
    run(tv);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule

// File: doc/loop_feedback_sched.md
Name: loop_feedback_sched

Overview:
- Schedules access to the single shared loop feedback path: the enable buffer, the pulse generator and the ok_feedback return.
- Round-robin arbitration between NUM_CH loop channels that request a feedback check.
- Drives enable_feedback for the granted channel and times the ok_feedback response with a latency counter. Retries on timeout.
- Reports pass/fail, measured latency and channel id to the loop/ATE status logic.

Parameters:
- NUM_CH, 4, number of requesting loop channels (2..8)
- CNT_W, 12, width of the latency counter and timeout compare
- TIMEOUT, 2000, cycles allowed from enable_feedback rise to synchronized ok_feedback
- MAX_RETRY, 2, extra attempts after the first timeout (0..7)
- GAP, 16, cooldown cycles with enable_feedback low between attempts and sessions

Ports:
- clk  in  1  block clock
- rst  in  1  synchronous reset, active-high
- req  in  NUM_CH  per-channel feedback-check request, level, held until its done
- abort  in  1  kill the current session; return to IDLE via cooldown
- ok_feedback  in  1  asynchronous feedback-good from the loop; 2-flop synchronized internally
- grant  out  NUM_CH  one-hot, held for the entire session including retries
- enable_feedback  out  1  registered drive to the feedback enable buffer
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse when the session ends
- pass  out  1  valid with done: ok seen within TIMEOUT
- timeout_err  out  1  valid with done: all attempts timed out, or aborted
- latency  out  CNT_W  valid with done: cycles from enable rise to synchronized ok on the passing attempt; all-ones on fail
- ch_id  out  $clog2(NUM_CH)  valid with done: granted channel index
- retries  out  3  valid with done: attempts used minus 1

Behaviour:
- Reset (sync, rst=1 at a clk edge):
  - State=IDLE.
  - grant, enable_feedback, busy, done, pass and timeout_err = 0.
  - latency = 0, ch_id = 0, retries = 0.
  - Round-robin pointer = channel 0.
  - Synchronizer flops = 0.
  - rst mid-session drops enable_feedback the same edge. No done is issued.
- IDLE:
  - If any req is set, go to ARB the next cycle.
- ARB (1 cycle):
  - Pick the first set req at or after the pointer, wrapping.
  - Register grant and ch_id. Pointer = granted+1 mod NUM_CH.
  - Clear the attempt count. Go to EN.
  - If req has dropped to all-zero, return to IDLE.
- EN:
  - enable_feedback=1 from the first EN cycle.
  - Counter cleared on entry and incremented each cycle.
  - Synchronized ok_feedback=1 -> capture counter into latency, go to COOL with result=pass.
  - Counter reaching TIMEOUT-1 with no ok:
    - If attempts < MAX_RETRY: increment attempts, go to COOL with result=retry.
    - Otherwise: go to COOL with result=fail.
  - ok and timeout in the same cycle -> pass wins.
  - ok_feedback already high on EN entry is still honoured: latency = synchronizer depth (2).
- COOL:
  - enable_feedback=0 for GAP cycles.
  - On exit: result=retry -> EN. pass/fail -> RPT.
- RPT (1 cycle):
  - done=1; pass/timeout_err/latency/retries presented.
  - grant cleared the following cycle. Go to IDLE.
  - Outputs hold their values until the next done.
- abort:
  - Honoured in ARB/EN. Go to COOL with result=fail; RPT then reports timeout_err=1, latency all-ones.
  - Ignored in COOL/RPT.
- Granted req dropping mid-session:
  - Session completes normally; no early exit.
- Counter:
  - Saturates at all-ones and never wraps.
  - TIMEOUT is checked at elaboration to be < 2^CNT_W.
- Sessions are non-overlapping; at most one grant bit is high at any time.

Decomposition:
- Shared package loop_fb_pkg:
  - state enum: IDLE, ARB, EN, COOL, RPT
  - result enum: PASS, RETRY, FAIL
  - constant SYNC_STAGES=2
- One sub-module: loop_fb_rr_arb. Combinational round-robin pick of req against the pointer. Outputs a one-hot vector and an index.
- The synchronizer uses the team's standard sync cell inline.

Test Plan:
- Single channel, NUM_CH=4:
  - Stimulus: req=0001; ok_feedback rises 100 cycles after enable_feedback rises.
  - Response: done with pass=1, latency=102 (100 + 2 sync), ch_id=0, retries=0.
  - grant=0001 throughout; enable_feedback low 16 cycles before done.
- Round-robin fairness:
  - Stimulus: req=1111 held; ok returned each time.
  - Response: ch_id sequence 0,1,2,3,0. Never two grant bits set.
- Timeout with retries, MAX_RETRY=2:
  - Stimulus: ok never asserts.
  - Response: exactly 3 enable_feedback pulses of 2000 cycles, separated by 16 low cycles. Then done with timeout_err=1, latency=FFF, retries=2.
- Pass on retry:
  - Stimulus: ok asserted only during the 2nd attempt, 50 cycles in.
  - Response: pass=1, latency=52, retries=1.
- Abort and simultaneous events:
  - Stimulus: abort mid-EN; separately, ok lands on the timeout cycle.
  - Response: the abort case reports timeout_err=1. The coincident case reports pass=1 with latency=1999.
- Reset mid-EN:
  - Stimulus: rst=1 for 1 cycle during EN.
  - Response: enable_feedback=0 and grant=0 at the next edge, no done pulse, round-robin pointer back to channel 0.
